// File: rtl/gate_bist_sequencer_if.sv
// Stimulus/response bundle between the gate BIST sequencer (slave) and the controller side (master).
interface gate_bist_sequencer_if #(
  parameter int ERR_W = 5
);
  logic             start;
  logic             abort;
  logic [6:0]       y_in;
  logic             a_out;
  logic             b_out;
  logic [1:0]       vec_idx;
  logic             busy;
  logic             done;
  logic             pass;
  logic [6:0]       fail_mask;
  logic [ERR_W-1:0] err_count;

  modport master (
    output start, abort, y_in,
    input  a_out, b_out, vec_idx, busy, done, pass, fail_mask, err_count
  );

  modport slave (
    input  start, abort, y_in,
    output a_out, b_out, vec_idx, busy, done, pass, fail_mask, err_count
  );
endinterface

// File: rtl/gate_bist_sequencer.sv
// Walks a/b through 00,01,10,11 and checks the 7 gate outputs; done 4*(SETTLE_CYCLES+1) edges after start.
// No backpressure: start is ignored while busy, abort wins over start and ends a run on the next edge.
module gate_bist_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_bist_sequencer_if.slave bus
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int SW = ((ERR_W > 3) ? ERR_W : 3) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic [1:0]       vec_q;
  logic [6:0]       mask_q;
  logic [ERR_W-1:0] err_q;

  logic [6:0]       expected;
  logic [6:0]       mism;
  logic [2:0]       pc;
  logic [SW-1:0]    sum;
  logic [ERR_W-1:0] err_nxt;
  logic [1:0]       vec_nxt;

  always_comb begin
    case (vec_q)
      2'd0:    expected = 7'h6C;
      2'd1:    expected = 7'h56;
      2'd2:    expected = 7'h16;
      default: expected = 7'h23;
    endcase
    mism = bus.y_in ^ expected;
    pc   = '0;
    for (int i = 0; i < 7; i++) pc = pc + {2'b00, mism[i]};
    sum     = SW'(err_q) + SW'(pc);
    err_nxt = (sum > SW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    vec_nxt = vec_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      vec_q  <= 2'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      mask_q <= '0;
      err_q  <= '0;
    end else if (bus.abort) begin
      // Partial fail_mask/err_count are kept for the controller to inspect.
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      vec_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec_q  <= 2'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            mask_q <= '0;
            err_q  <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= CW'(SETTLE_CYCLES);
            state  <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= SAMPLE;
        end
        SAMPLE: begin
          mask_q <= mask_q | mism;
          err_q  <= err_nxt;
          if (vec_q == 2'd3) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= ((mask_q | mism) == 7'h00);
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            vec_q  <= 2'd0;
          end else begin
            vec_q <= vec_nxt;
            a_q   <= vec_nxt[1];
            b_q   <= vec_nxt[0];
            cnt   <= CW'(SETTLE_CYCLES);
            state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Directed bench for gate_bist_sequencer: one DUT with SETTLE_CYCLES=2, one with SETTLE_CYCLES=0.
module tb_gate_bist_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  logic [6:0] sa0 = 7'h00;
  logic [6:0] sa1 = 7'h00;
  logic       force_en = 1'b0;
  logic [6:0] force_val = 7'h00;

  gate_bist_sequencer_if #(.ERR_W(5)) bif2 ();
  gate_bist_sequencer_if #(.ERR_W(5)) bif0 ();

  gate_bist_sequencer #(.SETTLE_CYCLES(2), .ERR_W(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bif2));
  gate_bist_sequencer #(.SETTLE_CYCLES(0), .ERR_W(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bif0));

  always #5 clk = ~clk;

  function automatic logic [6:0] gates(input logic a, input logic b);
    return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  assign bif2.y_in = force_en ? force_val : ((gates(bif2.a_out, bif2.b_out) & ~sa0) | sa1);
  assign bif0.y_in = force_en ? force_val : ((gates(bif0.a_out, bif0.b_out) & ~sa0) | sa1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif2.start = 0; bif2.abort = 0; bif0.start = 0; bif0.abort = 0;
    rst_n = 0;
    #12;
    vecs++;
    if ({bif2.busy, bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count, bif2.a_out, bif2.b_out, bif2.vec_idx} !== 17'd0) begin
      errs++; $display("FAIL reset_outputs: busy=%b done=%b pass=%b mask=%h err=%0d a=%b b=%b vec=%0d, required all 0",
        bif2.busy, bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count, bif2.a_out, bif2.b_out, bif2.vec_idx);
    end
    rst_n = 1;
    step();
  endtask

  // Start a SETTLE=2 run and check the a/b schedule and exact done timing.
  task automatic test_good_run();
    bif2.start = 1;
    step();
    bif2.start = 0;
    for (int k = 0; k < 12; k++) begin
      vecs++;
      if ({bif2.busy, bif2.done, bif2.a_out, bif2.b_out} !== {1'b1, 1'b0, 2'(k / 3)}) begin
        errs++; $display("FAIL good_sched k=%0d: busy=%b done=%b ab=%b%b, required busy=1 done=0 ab=%02b",
          k, bif2.busy, bif2.done, bif2.a_out, bif2.b_out, 2'(k / 3));
      end
      if (k < 11) step();
    end
    step();
    vecs++;
    if ({bif2.busy, bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count, bif2.vec_idx} !== {3'b011, 7'h00, 5'd0, 2'd0}) begin
      errs++; $display("FAIL good_done: busy=%b done=%b pass=%b mask=%h err=%0d vec=%0d, required 0 1 1 00 0 0",
        bif2.busy, bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count, bif2.vec_idx);
    end
  endtask

  task automatic test_xor_stuck();
    sa0 = 7'h10;
    bif2.start = 1;
    step();
    bif2.start = 0;
    repeat (12) step();
    sa0 = 7'h00;
    vecs++;
    if ({bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count} !== {2'b10, 7'h10, 5'd2}) begin
      errs++; $display("FAIL xor_stuck: done=%b pass=%b mask=%h err=%0d, required 1 0 10 2",
        bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count);
    end
  endtask

  // All outputs low: mismatches are the set bits of 6C,56,16,23 = 4+4+3+3.
  task automatic test_all_zero();
    force_en = 1; force_val = 7'h00;
    bif2.start = 1;
    step();
    bif2.start = 0;
    vecs++;
    if ({bif2.done, bif2.fail_mask, bif2.err_count} !== {1'b0, 7'h00, 5'd0}) begin
      errs++; $display("FAIL restart_clear: done=%b mask=%h err=%0d, required 0 00 0",
        bif2.done, bif2.fail_mask, bif2.err_count);
    end
    repeat (12) step();
    force_en = 0;
    vecs++;
    if ({bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count} !== {2'b10, 7'h7F, 5'd14}) begin
      errs++; $display("FAIL all_zero: done=%b pass=%b mask=%h err=%0d, required 1 0 7f 14",
        bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count);
    end
  endtask

  task automatic test_settle0();
    bif0.start = 1;
    step();
    bif0.start = 0;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if ({bif0.busy, bif0.done, bif0.vec_idx} !== {2'b10, 2'(k)}) begin
        errs++; $display("FAIL settle0_vec k=%0d: busy=%b done=%b vec=%0d, required 1 0 %0d",
          k, bif0.busy, bif0.done, bif0.vec_idx, k);
      end
      step();
    end
    vecs++;
    if ({bif0.busy, bif0.done, bif0.pass, bif0.fail_mask} !== {3'b011, 7'h00}) begin
      errs++; $display("FAIL settle0_done: busy=%b done=%b pass=%b mask=%h, required 0 1 1 00",
        bif0.busy, bif0.done, bif0.pass, bif0.fail_mask);
    end
  endtask

  task automatic test_abort();
    bif2.abort = 1;
    step();
    bif2.abort = 0;
    vecs++;
    if ({bif2.done, bif2.pass} !== 2'b00) begin
      errs++; $display("FAIL abort_idle: done=%b pass=%b, required 0 0", bif2.done, bif2.pass);
    end
    bif2.start = 1;
    step();
    bif2.start = 0;
    repeat (4) step();
    vecs++;
    if ({bif2.busy, bif2.a_out, bif2.b_out} !== 3'b101) begin
      errs++; $display("FAIL abort_pre: busy=%b ab=%b%b, required 1 01", bif2.busy, bif2.a_out, bif2.b_out);
    end
    bif2.abort = 1;
    step();
    bif2.abort = 0;
    vecs++;
    if ({bif2.busy, bif2.done, bif2.pass, bif2.a_out, bif2.b_out, bif2.vec_idx} !== 7'd0) begin
      errs++; $display("FAIL abort_run: busy=%b done=%b pass=%b ab=%b%b vec=%0d, required all 0",
        bif2.busy, bif2.done, bif2.pass, bif2.a_out, bif2.b_out, bif2.vec_idx);
    end
    bif2.abort = 1; bif2.start = 1;
    step();
    bif2.abort = 0; bif2.start = 0;
    vecs++;
    if (bif2.busy !== 1'b0) begin
      errs++; $display("FAIL abort_beats_start: busy=%b, required 0", bif2.busy);
    end
    bif2.start = 1;
    step();
    bif2.start = 0;
    repeat (12) step();
    vecs++;
    if ({bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count} !== {2'b11, 7'h00, 5'd0}) begin
      errs++; $display("FAIL after_abort: done=%b pass=%b mask=%h err=%0d, required 1 1 00 0",
        bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count);
    end
  endtask

  task automatic test_reset_midrun();
    sa1 = 7'h01;
    bif2.start = 1;
    step();
    bif2.start = 0;
    repeat (5) step();
    #2;
    rst_n = 0;
    #1;
    vecs++;
    if ({bif2.busy, bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count, bif2.a_out, bif2.b_out, bif2.vec_idx} !== 17'd0) begin
      errs++; $display("FAIL reset_midrun: busy=%b done=%b pass=%b mask=%h err=%0d a=%b b=%b vec=%0d, required all 0",
        bif2.busy, bif2.done, bif2.pass, bif2.fail_mask, bif2.err_count, bif2.a_out, bif2.b_out, bif2.vec_idx);
    end
    rst_n = 1;
    sa1 = 7'h00;
    step();
  endtask

  // start held high throughout the run must not restart or stretch it.
  task automatic test_back_to_back();
    bif2.start = 1;
    step();
    for (int k = 1; k < 12; k++) begin
      step();
      vecs++;
      if ({bif2.busy, bif2.done} !== 2'b10) begin
        errs++; $display("FAIL held_start k=%0d: busy=%b done=%b, required 1 0", k, bif2.busy, bif2.done);
      end
    end
    step();
    bif2.start = 0;
    vecs++;
    if ({bif2.busy, bif2.done, bif2.pass} !== 3'b011) begin
      errs++; $display("FAIL held_start_done: busy=%b done=%b pass=%b, required 0 1 1", bif2.busy, bif2.done, bif2.pass);
    end
    bif2.start = 1;
    step();
    bif2.start = 0;
    vecs++;
    if ({bif2.busy, bif2.done, bif2.pass} !== 3'b100) begin
      errs++; $display("FAIL restart_done: busy=%b done=%b pass=%b, required 1 0 0", bif2.busy, bif2.done, bif2.pass);
    end
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_xor_stuck();
    test_all_zero();
    test_settle0();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
